// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions: ALU opcodes, register-zero constant,
// bypass source select and the EX-stage control payload.
package mips_pkg;

  localparam int unsigned REG_W  = 5;
  localparam int unsigned ALU_W  = 4;

  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic [ALU_W-1:0] {
    ALU_AND = 4'd0,
    ALU_OR  = 4'd1,
    ALU_ADD = 4'd2,
    ALU_SUB = 4'd6,
    ALU_SLT = 4'd7,
    ALU_NOR = 4'd12
  } alu_ctrl_t;

  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_EX  = 2'd1,
    FWD_MEM = 2'd2,
    FWD_WB  = 2'd3
  } fwd_sel_t;

  // Control fields carried from ID into EX.
  typedef struct packed {
    logic [REG_W-1:0] rw;
    logic             reg_wr;
    logic             mem_rd;
    logic             mem_wr;
    logic [ALU_W-1:0] alu_ctrl;
    logic             valid;
  } ex_ctrl_t;

endpackage

// File: rtl/forward_mux.sv
// Per-operand bypass selector. Priority EX > MEM > WB > register file;
// register 0 always reads as zero.
//   src      : source register number
//   rf_data  : register file read data
//   *_en/*_rw/*_data : bypass tuple from EX, MEM, WB
//   data     : selected operand value
//   sel      : which source was chosen (debug)
module forward_mux
  import mips_pkg::*;
#(
  parameter int unsigned W = 32
) (
  input  logic [REG_W-1:0] src,
  input  logic [W-1:0]     rf_data,
  input  logic             ex_en,
  input  logic [REG_W-1:0] ex_rw,
  input  logic [W-1:0]     ex_data,
  input  logic             mem_en,
  input  logic [REG_W-1:0] mem_rw,
  input  logic [W-1:0]     mem_data,
  input  logic             wb_en,
  input  logic [REG_W-1:0] wb_rw,
  input  logic [W-1:0]     wb_data,
  output logic [W-1:0]     data,
  output fwd_sel_t         sel
);

  always_comb begin
    data = rf_data;
    sel  = FWD_RF;
    if (src == REG_ZERO) begin
      data = '0;
      sel  = FWD_RF;
    end else if (ex_en && (ex_rw == src)) begin
      data = ex_data;
      sel  = FWD_EX;
    end else if (mem_en && (mem_rw == src)) begin
      data = mem_data;
      sel  = FWD_MEM;
    end else if (wb_en && (wb_rw == src)) begin
      data = wb_data;
      sel  = FWD_WB;
    end
  end

endmodule

// File: rtl/operand_stage.sv
// ID/EX pipeline stage: forwards operands, detects load-use hazards,
// accepts mispredict flushes and registers operands/control for EX.
//   Clk/Resetn        : clock, async active-low reset
//   BusA/BusB, RA/RB  : register file data and source registers
//   ID_*              : decoded instruction in ID
//   EX_Result, MEM_*, WB_* : bypass sources
//   Flush             : kill the ID instruction
//   Stall             : hold PC and IF/ID (combinational)
//   EX_*              : registered operands and control for EX
//   StallCount/FlushCount : saturating performance counters
module operand_stage
  import mips_pkg::*;
#(
  parameter int unsigned W  = 32,
  parameter int unsigned CW = 32
) (
  input  logic          Clk,
  input  logic          Resetn,
  input  logic [W-1:0]  BusA,
  input  logic [W-1:0]  BusB,
  input  logic [4:0]    RA,
  input  logic [4:0]    RB,
  input  logic          ID_UseA,
  input  logic          ID_UseB,
  input  logic [W-1:0]  ID_Imm,
  input  logic [4:0]    ID_RW,
  input  logic          ID_RegWr,
  input  logic          ID_MemRd,
  input  logic          ID_MemWr,
  input  logic          ID_ALUSrc,
  input  logic [3:0]    ID_ALUCtrl,
  input  logic          ID_Valid,
  input  logic [W-1:0]  EX_Result,
  input  logic [W-1:0]  MEM_Result,
  input  logic [4:0]    MEM_RW,
  input  logic          MEM_RegWr,
  input  logic [W-1:0]  WB_BusW,
  input  logic [4:0]    WB_RW,
  input  logic          WB_RegWr,
  input  logic          Flush,
  output logic          Stall,
  output logic [W-1:0]  EX_OpA,
  output logic [W-1:0]  EX_OpB,
  output logic [W-1:0]  EX_StoreData,
  output logic [4:0]    EX_RW,
  output logic          EX_RegWr,
  output logic          EX_MemRd,
  output logic          EX_MemWr,
  output logic [3:0]    EX_ALUCtrl,
  output logic          EX_Valid,
  output logic [CW-1:0] StallCount,
  output logic [CW-1:0] FlushCount
);

  logic [W-1:0] fwd_a;
  logic [W-1:0] fwd_b;
  logic [W-1:0] op_b;
  fwd_sel_t     sel_a;
  fwd_sel_t     sel_b;
  logic         unused_sel;
  logic         ex_fwd_en;
  logic         load_use;
  ex_ctrl_t     id_ctrl;

  // A load in EX has no result yet, so it must not be bypassed from EX.
  assign ex_fwd_en = EX_Valid & EX_RegWr & ~EX_MemRd;

  forward_mux #(.W(W)) u_fwd_a (
    .src(RA), .rf_data(BusA),
    .ex_en(ex_fwd_en), .ex_rw(EX_RW), .ex_data(EX_Result),
    .mem_en(MEM_RegWr), .mem_rw(MEM_RW), .mem_data(MEM_Result),
    .wb_en(WB_RegWr), .wb_rw(WB_RW), .wb_data(WB_BusW),
    .data(fwd_a), .sel(sel_a)
  );

  forward_mux #(.W(W)) u_fwd_b (
    .src(RB), .rf_data(BusB),
    .ex_en(ex_fwd_en), .ex_rw(EX_RW), .ex_data(EX_Result),
    .mem_en(MEM_RegWr), .mem_rw(MEM_RW), .mem_data(MEM_Result),
    .wb_en(WB_RegWr), .wb_rw(WB_RW), .wb_data(WB_BusW),
    .data(fwd_b), .sel(sel_b)
  );

  assign unused_sel = ^{sel_a, sel_b};

  // EX_Valid gating keeps bubble data fields from raising a hazard;
  // reset clears EX_Valid asynchronously, so Stall drops with it.
  assign load_use = ID_Valid & EX_Valid & EX_MemRd & (EX_RW != REG_ZERO) &
                    ((ID_UseA & (EX_RW == RA)) | (ID_UseB & (EX_RW == RB)));

  assign Stall = load_use & ~Flush;

  assign op_b = ID_ALUSrc ? ID_Imm : fwd_b;

  always_comb begin
    id_ctrl          = '0;
    id_ctrl.rw       = ID_RW;
    id_ctrl.reg_wr   = ID_RegWr & ID_Valid;
    id_ctrl.mem_rd   = ID_MemRd & ID_Valid;
    id_ctrl.mem_wr   = ID_MemWr & ID_Valid;
    id_ctrl.alu_ctrl = ID_ALUCtrl;
    id_ctrl.valid    = ID_Valid;
  end

  // ID/EX register; flush and stall both insert an all-zero bubble.
  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      EX_OpA       <= '0;
      EX_OpB       <= '0;
      EX_StoreData <= '0;
      EX_RW        <= '0;
      EX_RegWr     <= 1'b0;
      EX_MemRd     <= 1'b0;
      EX_MemWr     <= 1'b0;
      EX_ALUCtrl   <= '0;
      EX_Valid     <= 1'b0;
    end else if (Flush || Stall) begin
      EX_OpA       <= '0;
      EX_OpB       <= '0;
      EX_StoreData <= '0;
      EX_RW        <= '0;
      EX_RegWr     <= 1'b0;
      EX_MemRd     <= 1'b0;
      EX_MemWr     <= 1'b0;
      EX_ALUCtrl   <= '0;
      EX_Valid     <= 1'b0;
    end else begin
      EX_OpA       <= fwd_a;
      EX_OpB       <= op_b;
      EX_StoreData <= fwd_b;
      EX_RW        <= id_ctrl.rw;
      EX_RegWr     <= id_ctrl.reg_wr;
      EX_MemRd     <= id_ctrl.mem_rd;
      EX_MemWr     <= id_ctrl.mem_wr;
      EX_ALUCtrl   <= id_ctrl.alu_ctrl;
      EX_Valid     <= id_ctrl.valid;
    end
  end

  // Saturating counters; Stall is already masked by Flush.
  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      StallCount <= '0;
      FlushCount <= '0;
    end else begin
      if (Flush && (FlushCount != '1)) FlushCount <= FlushCount + CW'(1);
      if (Stall && (StallCount != '1)) StallCount <= StallCount + CW'(1);
    end
  end

endmodule

// File: tb/tb_operand_stage.sv
// Scoreboard bench for operand_stage: directed vectors push expected EX
// contents; a monitor pops and compares one entry after each clock edge.
module tb_operand_stage;
  import mips_pkg::*;

  localparam int unsigned W  = 32;
  localparam int unsigned CW = 4;

  logic          Clk, Resetn;
  logic [W-1:0]  BusA, BusB, ID_Imm, EX_Result, MEM_Result, WB_BusW;
  logic [4:0]    RA, RB, ID_RW, MEM_RW, WB_RW;
  logic          ID_UseA, ID_UseB, ID_RegWr, ID_MemRd, ID_MemWr, ID_ALUSrc, ID_Valid;
  logic [3:0]    ID_ALUCtrl;
  logic          MEM_RegWr, WB_RegWr, Flush, Stall;
  logic [W-1:0]  EX_OpA, EX_OpB, EX_StoreData;
  logic [4:0]    EX_RW;
  logic          EX_RegWr, EX_MemRd, EX_MemWr, EX_Valid;
  logic [3:0]    EX_ALUCtrl;
  logic [CW-1:0] StallCount, FlushCount;

  operand_stage #(.W(W), .CW(CW)) dut (
    .Clk(Clk), .Resetn(Resetn), .BusA(BusA), .BusB(BusB), .RA(RA), .RB(RB),
    .ID_UseA(ID_UseA), .ID_UseB(ID_UseB), .ID_Imm(ID_Imm), .ID_RW(ID_RW),
    .ID_RegWr(ID_RegWr), .ID_MemRd(ID_MemRd), .ID_MemWr(ID_MemWr),
    .ID_ALUSrc(ID_ALUSrc), .ID_ALUCtrl(ID_ALUCtrl), .ID_Valid(ID_Valid),
    .EX_Result(EX_Result), .MEM_Result(MEM_Result), .MEM_RW(MEM_RW),
    .MEM_RegWr(MEM_RegWr), .WB_BusW(WB_BusW), .WB_RW(WB_RW), .WB_RegWr(WB_RegWr),
    .Flush(Flush), .Stall(Stall), .EX_OpA(EX_OpA), .EX_OpB(EX_OpB),
    .EX_StoreData(EX_StoreData), .EX_RW(EX_RW), .EX_RegWr(EX_RegWr),
    .EX_MemRd(EX_MemRd), .EX_MemWr(EX_MemWr), .EX_ALUCtrl(EX_ALUCtrl),
    .EX_Valid(EX_Valid), .StallCount(StallCount), .FlushCount(FlushCount)
  );

  typedef struct packed {
    logic [W-1:0] opa;
    logic [W-1:0] opb;
    logic [W-1:0] sd;
    logic [4:0]   rw;
    logic         regwr;
    logic         memrd;
    logic         memwr;
    logic [3:0]   alu;
    logic         valid;
  } exp_t;

  localparam exp_t BUBBLE = '0;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic exp_t mk(input logic [W-1:0] opa, input logic [W-1:0] opb,
                              input logic [W-1:0] sd, input logic [4:0] rw,
                              input logic regwr, input logic memrd, input logic memwr,
                              input logic [3:0] alu, input logic valid);
    exp_t e;
    e = '{opa, opb, sd, rw, regwr, memrd, memwr, alu, valid};
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare the registered EX contents one edge after each push.
  initial begin
    exp_t e, got;
    forever begin
      @(posedge Clk);
      #1;
      if (sb_q.size() > 0) begin
        e   = sb_q.pop_front();
        got = '{EX_OpA, EX_OpB, EX_StoreData, EX_RW, EX_RegWr, EX_MemRd,
                EX_MemWr, EX_ALUCtrl, EX_Valid};
        checks++;
        if (got !== e) begin
          errors++;
          $display("FAIL ex_regs: got %h expected %h at %0t", got, e, $time);
        end
      end
    end
  end

  task automatic clr();
    BusA = '0; BusB = '0; RA = '0; RB = '0; ID_UseA = 0; ID_UseB = 0;
    ID_Imm = '0; ID_RW = '0; ID_RegWr = 0; ID_MemRd = 0; ID_MemWr = 0;
    ID_ALUSrc = 0; ID_ALUCtrl = '0; ID_Valid = 0;
    EX_Result = '0; MEM_Result = '0; MEM_RW = '0; MEM_RegWr = 0;
    WB_BusW = '0; WB_RW = '0; WB_RegWr = 0; Flush = 0;
  endtask

  // Inputs are set just after a falling edge; check Stall, queue the
  // expected EX contents and advance to the next falling edge.
  task automatic step(input string name, input logic exp_stall, input exp_t e);
    #1;
    chk(name, 64'(Stall), 64'(exp_stall));
    sb_q.push_back(e);
    @(negedge Clk);
  endtask

  task automatic load(input logic [4:0] rw);
    clr();
    ID_RW = rw; ID_RegWr = 1; ID_MemRd = 1; ID_ALUCtrl = ALU_ADD; ID_Valid = 1;
    step("stall_load", 1'b0, mk('0, '0, '0, rw, 1, 1, 0, ALU_ADD, 1));
  endtask

  initial begin
    clr();
    Resetn = 1'b0;
    @(negedge Clk);
    chk("rst_stall", 64'(Stall), 64'd0);
    chk("rst_valid", 64'(EX_Valid), 64'd0);
    chk("rst_opa", 64'(EX_OpA), 64'd0);
    chk("rst_cnt", 64'({StallCount, FlushCount}), 64'd0);
    Resetn = 1'b1;

    // Plain ADD, no bypass
    clr(); RA = 1; RB = 2; ID_UseA = 1; ID_UseB = 1; BusA = 5; BusB = 7;
    ID_RW = 5; ID_RegWr = 1; ID_ALUCtrl = ALU_ADD; ID_Valid = 1;
    step("stall_add", 0, mk(5, 7, 7, 5, 1, 0, 0, ALU_ADD, 1));
    chk("cnt_add", 64'({StallCount, FlushCount}), 64'd0);

    // r0 reads zero regardless of bus
    clr(); ID_UseA = 1; ID_UseB = 1; BusA = 32'hdead; BusB = 32'hbeef;
    ID_RW = 3; ID_RegWr = 1; ID_ALUCtrl = ALU_OR; ID_Valid = 1;
    step("stall_r0", 0, mk(0, 0, 0, 3, 1, 0, 0, ALU_OR, 1));

    // EX beats MEM and WB; ALUSrc picks immediate
    clr(); EX_Result = 32'h11; MEM_RW = 3; MEM_RegWr = 1; MEM_Result = 32'h22;
    WB_RW = 3; WB_RegWr = 1; WB_BusW = 32'h33; BusA = 32'h44;
    RA = 3; ID_UseA = 1; ID_ALUSrc = 1; ID_Imm = 32'h100;
    ID_RW = 6; ID_RegWr = 1; ID_ALUCtrl = ALU_SUB; ID_Valid = 1;
    step("stall_fwd_ex", 0, mk(32'h11, 32'h100, 0, 6, 1, 0, 0, ALU_SUB, 1));

    // EX now writes r6: MEM wins for r3 (store)
    clr(); EX_Result = 32'h11; MEM_RW = 3; MEM_RegWr = 1; MEM_Result = 32'h22;
    WB_RW = 3; WB_RegWr = 1; WB_BusW = 32'h33; BusA = 32'h44; BusB = 32'h45;
    RA = 3; RB = 3; ID_UseA = 1; ID_UseB = 1;
    ID_RW = 7; ID_MemWr = 1; ID_ALUCtrl = ALU_ADD; ID_Valid = 1;
    step("stall_fwd_mem", 0, mk(32'h22, 32'h22, 32'h22, 7, 0, 0, 1, ALU_ADD, 1));

    // MEM disabled: WB wins for A; B from register file
    clr(); MEM_RW = 3; MEM_Result = 32'h22; WB_RW = 3; WB_RegWr = 1; WB_BusW = 32'h33;
    RA = 3; RB = 9; BusA = 32'h44; BusB = 32'h55; ID_UseA = 1; ID_UseB = 1;
    ID_ALUCtrl = ALU_AND; ID_Valid = 1;
    step("stall_fwd_wb", 0, mk(32'h33, 32'h55, 32'h55, 0, 0, 0, 0, ALU_AND, 1));

    // Load r4, then dependent use of r4 on B
    clr(); RA = 1; BusA = 32'h1000; ID_UseA = 1; ID_ALUSrc = 1; ID_Imm = 4;
    ID_RW = 4; ID_RegWr = 1; ID_MemRd = 1; ID_ALUCtrl = ALU_ADD; ID_Valid = 1;
    step("stall_lw", 0, mk(32'h1000, 4, 0, 4, 1, 1, 0, ALU_ADD, 1));
    clr(); RA = 2; BusA = 32'h20; RB = 4; BusB = 32'h66; ID_UseA = 1; ID_UseB = 1;
    EX_Result = 32'hbad; ID_RW = 8; ID_RegWr = 1; ID_ALUCtrl = ALU_ADD; ID_Valid = 1;
    step("stall_lu", 1, BUBBLE);
    chk("cnt_lu", 64'(StallCount), 64'd1);
    MEM_RW = 4; MEM_RegWr = 1; MEM_Result = 32'h99;
    step("stall_lu_rel", 0, mk(32'h20, 32'h99, 32'h99, 8, 1, 0, 0, ALU_ADD, 1));

    // False hazards: UseB=0, ID not valid, load to r0
    load(4);
    clr(); EX_Result = 32'hbad; RA = 1; ID_UseA = 1; BusA = 7; RB = 4; BusB = 8;
    ID_ALUSrc = 1; ID_Imm = 32'h10; ID_RW = 4; ID_RegWr = 1; ID_MemRd = 1;
    ID_ALUCtrl = ALU_ADD; ID_Valid = 1;
    step("stall_nouse", 0, mk(7, 32'h10, 8, 4, 1, 1, 0, ALU_ADD, 1));
    clr(); EX_Result = 32'hbad; RB = 4; ID_UseB = 1; BusB = 32'ha;
    ID_RegWr = 1; ID_MemRd = 1; ID_ALUCtrl = ALU_AND; ID_Valid = 0;
    step("stall_idinv", 0, mk(0, 32'ha, 32'ha, 0, 0, 0, 0, ALU_AND, 0));
    load(0);
    clr(); ID_UseA = 1; ID_UseB = 1; BusA = 32'h77; BusB = 32'h78;
    ID_RW = 9; ID_ALUCtrl = ALU_SLT; ID_Valid = 1;
    step("stall_rw0", 0, mk(0, 0, 0, 9, 0, 0, 0, ALU_SLT, 1));
    chk("cnt_false", 64'(StallCount), 64'd1);

    // Flush beats hazard
    load(4);
    clr(); RB = 4; ID_UseB = 1; ID_RW = 8; ID_RegWr = 1; ID_Valid = 1; Flush = 1;
    step("stall_flush", 0, BUBBLE);
    chk("cnt_flush", 64'(FlushCount), 64'd1);
    chk("cnt_flush_st", 64'(StallCount), 64'd1);

    // RA==RB==load dest: single stall, both from MEM
    load(5);
    clr(); RA = 5; RB = 5; ID_UseA = 1; ID_UseB = 1; BusA = 1; BusB = 2;
    ID_RW = 10; ID_RegWr = 1; ID_ALUCtrl = ALU_SUB; ID_Valid = 1;
    step("stall_ab", 1, BUBBLE);
    chk("cnt_ab", 64'(StallCount), 64'd2);
    MEM_RW = 5; MEM_RegWr = 1; MEM_Result = 32'hab;
    step("stall_ab_rel", 0, mk(32'hab, 32'hab, 32'hab, 10, 1, 0, 0, ALU_SUB, 1));

    // Drive StallCount past its 4-bit ceiling
    for (int i = 0; i < 14; i++) begin
      load(4);
      clr(); RB = 4; ID_UseB = 1; ID_RW = 8; ID_RegWr = 1; ID_Valid = 1;
      step("stall_sat", 1, BUBBLE);
    end
    chk("cnt_sat", 64'(StallCount), 64'd15);
    chk("cnt_sat_fl", 64'(FlushCount), 64'd1);

    // Reset in the middle of a stall cycle
    load(4);
    clr(); RB = 4; ID_UseB = 1; ID_RW = 8; ID_RegWr = 1; ID_Valid = 1;
    #1;
    chk("pre_rst_stall", 64'(Stall), 64'd1);
    #2;
    Resetn = 1'b0;
    #1;
    chk("mid_rst_stall", 64'(Stall), 64'd0);
    chk("mid_rst_valid", 64'(EX_Valid), 64'd0);
    chk("mid_rst_memrd", 64'({EX_MemRd, EX_RW}), 64'd0);
    chk("mid_rst_cnt", 64'({StallCount, FlushCount}), 64'd0);
    @(negedge Clk);
    Resetn = 1'b1;
    clr();
    repeat (2) @(negedge Clk);
    chk("sb_drained", 64'(sb_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Safety net against a hung run.
  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

endmodule
